// File: rtl/target_scheduler_pkg.sv
// Shared types for the target scheduler: lane index type, FSM state enum and lane wrap helper.
package target_pkg;

  localparam int NUM_LANES_DEF = 10;
  localparam int LANE_W        = 4;

  typedef logic [LANE_W-1:0] lane_t;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_PROBE = 2'd1,
    ST_SPAWN = 2'd2
  } state_t;

  function automatic lane_t next_lane(lane_t lane, int num_lanes);
    return (int'(lane) == num_lanes - 1) ? '0 : lane + 1'b1;
  endfunction

endpackage

// File: rtl/target_scheduler_if.sv
// Playfield-side bundle of the target scheduler; dbg_state exposes the spawn FSM.
interface target_scheduler_if
  import target_pkg::*;
#(
  parameter int NUM_LANES = NUM_LANES_DEF
);
  // No backpressure anywhere: hit_valid is a one-cycle strobe sampled on the
  // rising edge, and every result (hit_ok/hit_miss, spawn_pulse, expire_mask)
  // is a registered one-cycle pulse the consumer must take when it appears.
  logic                 enable;
  logic [31:0]          score;
  logic [31:0]          rand_in;
  logic                 hit_valid;
  lane_t                hit_lane;
  logic [NUM_LANES-1:0] active_mask;
  logic                 spawn_pulse;
  lane_t                spawn_lane;
  logic [NUM_LANES-1:0] expire_mask;
  logic                 hit_ok;
  logic                 hit_miss;
  logic [15:0]          skip_count;
  state_t               dbg_state;

  modport master (
    output enable, score, rand_in, hit_valid, hit_lane,
    input  active_mask, spawn_pulse, spawn_lane, expire_mask,
    input  hit_ok, hit_miss, skip_count, dbg_state
  );

  modport slave (
    input  enable, score, rand_in, hit_valid, hit_lane,
    output active_mask, spawn_pulse, spawn_lane, expire_mask,
    output hit_ok, hit_miss, skip_count, dbg_state
  );
endinterface

// File: rtl/target_scheduler_lane_timer.sv
// Per-lane lifetime counter: load on spawn, count down on game ticks, flag the 1->0 step.
module lane_timer #(
  parameter int LIFETIME = 6,
  parameter int CNT_W    = 3
) (
  input  logic clock,
  input  logic resetn,
  input  logic i_clear,
  input  logic i_load,
  input  logic i_tick,
  output logic o_expiring
);
  logic [CNT_W-1:0] r_cnt;

  // A clear (hit or game stop) always beats the natural expiry of the lane.
  assign o_expiring = i_tick && !i_clear && !i_load && (r_cnt == CNT_W'(1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CNT_W'(LIFETIME);
    end else if (i_tick && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end
endmodule

// File: rtl/target_scheduler.sv
// Target spawn sequencer: tick divider, WAIT/PROBE/SPAWN FSM, hit resolution and active mask.
// Optional TARGET_SPEEDUP_EN shortens the spawn interval as the score grows.
module target_scheduler
  import target_pkg::*;
#(
  parameter int NUM_LANES     = NUM_LANES_DEF,
  parameter int TICK_DIV      = 25000000,
  parameter int BASE_INTERVAL = 8,
  parameter int MIN_INTERVAL  = 2,
  parameter int SCORE_STEP    = 100,
  parameter int LIFETIME      = 6
) (
  input  logic              clock,
  input  logic              resetn,
  target_scheduler_if.slave bus
);
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_W  = $clog2(LIFETIME + 1);

  state_t               r_state;
  logic [TICK_W-1:0]    r_tick_cnt;
  logic [15:0]          r_interval;
  lane_t                r_probe_lane;
  lane_t                r_probe_cnt;
  logic [NUM_LANES-1:0] r_mask;
  logic [NUM_LANES-1:0] r_expire_mask;
  logic                 r_spawn_pulse;
  lane_t                r_spawn_lane;
  logic                 r_hit_ok;
  logic                 r_hit_miss;
  logic [15:0]          r_skip_count;

  logic                 w_tick;
  logic                 w_hit_ok;
  logic [15:0]          w_reload;
  logic [NUM_LANES-1:0] w_hit_vec;
  logic [NUM_LANES-1:0] w_spawn_vec;
  logic [NUM_LANES-1:0] w_clear;
  logic [NUM_LANES-1:0] w_expiring;

  assign w_tick      = bus.enable && (r_tick_cnt == TICK_W'(TICK_DIV - 1));
  assign w_hit_ok    = bus.hit_valid && (int'(bus.hit_lane) < NUM_LANES) && r_mask[bus.hit_lane];
  assign w_hit_vec   = w_hit_ok ? (NUM_LANES'(1) << bus.hit_lane) : '0;
  assign w_spawn_vec = (r_state == ST_SPAWN) ? (NUM_LANES'(1) << r_probe_lane) : '0;
  assign w_clear     = bus.enable ? w_hit_vec : '1;

`ifdef TARGET_SPEEDUP_EN
  logic [31:0] w_steps;
  // Clamp on the step count first so the subtraction can never wrap.
  always_comb begin
    w_steps = bus.score / 32'(SCORE_STEP);
    if (w_steps >= 32'(BASE_INTERVAL - MIN_INTERVAL)) begin
      w_reload = 16'(MIN_INTERVAL);
    end else begin
      w_reload = 16'(32'(BASE_INTERVAL) - w_steps);
    end
  end
`else
  logic w_unused_score;
  assign w_unused_score = ^bus.score;
  assign w_reload       = 16'(BASE_INTERVAL);
`endif

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lane_timer #(
      .LIFETIME(LIFETIME),
      .CNT_W   (CNT_W)
    ) u_timer (
      .clock     (clock),
      .resetn    (resetn),
      .i_clear   (w_clear[g]),
      .i_load    (w_spawn_vec[g]),
      .i_tick    (w_tick),
      .o_expiring(w_expiring[g])
    );
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state       <= ST_WAIT;
      r_tick_cnt    <= '0;
      r_interval    <= 16'(BASE_INTERVAL);
      r_probe_lane  <= '0;
      r_probe_cnt   <= '0;
      r_mask        <= '0;
      r_expire_mask <= '0;
      r_spawn_pulse <= 1'b0;
      r_spawn_lane  <= '0;
      r_hit_ok      <= 1'b0;
      r_hit_miss    <= 1'b0;
      r_skip_count  <= '0;
    end else if (!bus.enable) begin
      r_state       <= ST_WAIT;
      r_tick_cnt    <= '0;
      r_interval    <= w_reload;
      r_mask        <= '0;
      r_expire_mask <= '0;
      r_spawn_pulse <= 1'b0;
      r_hit_ok      <= 1'b0;
      r_hit_miss    <= 1'b0;
    end else begin
      r_tick_cnt    <= w_tick ? '0 : r_tick_cnt + 1'b1;
      r_hit_ok      <= w_hit_ok;
      r_hit_miss    <= bus.hit_valid && !w_hit_ok;
      r_expire_mask <= w_expiring;
      r_mask        <= (r_mask & ~w_hit_vec & ~w_expiring) | w_spawn_vec;
      r_spawn_pulse <= 1'b0;
      case (r_state)
        ST_WAIT: begin
          if (w_tick) begin
            r_interval <= r_interval - 1'b1;
            if (r_interval == 16'd1) begin
              r_state      <= ST_PROBE;
              r_probe_lane <= LANE_W'(bus.rand_in % 32'(NUM_LANES));
              r_probe_cnt  <= '0;
            end
          end
        end
        ST_PROBE: begin
          if (!r_mask[r_probe_lane]) begin
            r_state <= ST_SPAWN;
          end else if (r_probe_cnt == LANE_W'(NUM_LANES - 1)) begin
            if (r_skip_count != 16'hFFFF) r_skip_count <= r_skip_count + 1'b1;
            r_interval <= w_reload;
            r_state    <= ST_WAIT;
          end else begin
            r_probe_lane <= next_lane(r_probe_lane, NUM_LANES);
            r_probe_cnt  <= r_probe_cnt + 1'b1;
          end
        end
        ST_SPAWN: begin
          r_spawn_pulse <= 1'b1;
          r_spawn_lane  <= r_probe_lane;
          r_interval    <= w_reload;
          r_state       <= ST_WAIT;
        end
        default: r_state <= ST_WAIT;
      endcase
    end
  end

  assign bus.active_mask = r_mask;
  assign bus.expire_mask = r_expire_mask;
  assign bus.spawn_pulse = r_spawn_pulse;
  assign bus.spawn_lane  = r_spawn_lane;
  assign bus.hit_ok      = r_hit_ok;
  assign bus.hit_miss    = r_hit_miss;
  assign bus.skip_count  = r_skip_count;
  assign bus.dbg_state   = r_state;
endmodule

// File: tb/tb_target_scheduler.sv
// Bench for target_scheduler: two instances (game timing and a dense-spawn setup) against a lane-lifetime model.
module tb_target_scheduler;
  import target_pkg::*;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  target_scheduler_if #(.NUM_LANES(10)) if0 ();
  target_scheduler_if #(.NUM_LANES(10)) if1 ();

  target_scheduler #(.NUM_LANES(10), .TICK_DIV(4), .BASE_INTERVAL(8), .MIN_INTERVAL(2),
                     .SCORE_STEP(100), .LIFETIME(6))
    u_dut0 (.clock(clock), .resetn(resetn), .bus(if0.slave));

  target_scheduler #(.NUM_LANES(10), .TICK_DIV(2), .BASE_INTERVAL(2), .MIN_INTERVAL(1),
                     .SCORE_STEP(100), .LIFETIME(40))
    u_dut1 (.clock(clock), .resetn(resetn), .bus(if1.slave));

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_q[$];

  // Reference model: lane remaining lifetimes in ticks, plus attempt bookkeeping.
  int m_timer[2][10];
  int m_tick[2], m_int[2], m_probing[2], m_probe_lane[2], m_probe_cnt[2], m_pending[2];
  int m_spawn[2], m_lane[2], m_exp[2], m_ok[2], m_miss[2], m_skip[2];

  logic        in_en[2];
  logic [31:0] in_sc[2], in_rnd[2];
  logic        in_hv[2];
  logic [3:0]  in_hl[2];
  int          dis_left[2];
  logic [31:0] cur_score;

  function automatic int p_tdiv(int k); return (k == 0) ? 4 : 2; endfunction
  function automatic int p_base(int k); return (k == 0) ? 8 : 2; endfunction
  function automatic int p_min(int k);  return (k == 0) ? 2 : 1; endfunction
  function automatic int p_life(int k); return (k == 0) ? 6 : 40; endfunction

  function automatic int m_reload(int k, logic [31:0] sc);
`ifdef TARGET_SPEEDUP_EN
    logic [31:0] d;
    d = sc / 100;
    if (d >= 32'(p_base(k) - p_min(k))) return p_min(k);
    return p_base(k) - int'(d);
`else
    return p_base(k) + 0 * int'(sc[0]);
`endif
  endfunction

  function automatic logic [31:0] m_mask(int k);
    logic [31:0] m = '0;
    for (int i = 0; i < 10; i++) if (m_timer[k][i] > 0) m[i] = 1'b1;
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset(input int k);
    for (int i = 0; i < 10; i++) m_timer[k][i] = 0;
    m_tick[k] = 0; m_int[k] = p_base(k); m_probing[k] = 0; m_pending[k] = -1;
    m_probe_lane[k] = 0; m_probe_cnt[k] = 0;
    m_spawn[k] = 0; m_lane[k] = 0; m_exp[k] = 0; m_ok[k] = 0; m_miss[k] = 0; m_skip[k] = 0;
  endtask

  task automatic model_step(input int k);
    bit tick;
    bit busy_pre[10];
    int hit_lane_i;
    m_spawn[k] = 0; m_exp[k] = 0; m_ok[k] = 0; m_miss[k] = 0;
    if (!in_en[k]) begin
      for (int i = 0; i < 10; i++) m_timer[k][i] = 0;
      m_tick[k] = 0; m_int[k] = m_reload(k, in_sc[k]); m_probing[k] = 0; m_pending[k] = -1;
      return;
    end
    tick = (m_tick[k] == p_tdiv(k) - 1);
    m_tick[k] = tick ? 0 : m_tick[k] + 1;
    for (int i = 0; i < 10; i++) busy_pre[i] = (m_timer[k][i] > 0);
    hit_lane_i = -1;
    if (in_hv[k]) begin
      if (int'(in_hl[k]) < 10) begin
        if (busy_pre[in_hl[k]]) hit_lane_i = int'(in_hl[k]);
      end
      if (hit_lane_i >= 0) m_ok[k] = 1; else m_miss[k] = 1;
    end
    for (int i = 0; i < 10; i++) begin
      if (i == hit_lane_i) m_timer[k][i] = 0;
      else if (tick && m_timer[k][i] > 0) begin
        m_timer[k][i]--;
        if (m_timer[k][i] == 0) m_exp[k] |= (1 << i);
      end
    end
    if (m_pending[k] >= 0) begin
      m_timer[k][m_pending[k]] = p_life(k);
      m_spawn[k] = 1; m_lane[k] = m_pending[k];
      m_int[k] = m_reload(k, in_sc[k]); m_pending[k] = -1;
    end else if (m_probing[k] != 0) begin
      if (!busy_pre[m_probe_lane[k]]) begin
        m_pending[k] = m_probe_lane[k]; m_probing[k] = 0;
      end else begin
        m_probe_lane[k] = (m_probe_lane[k] + 1) % 10;
        m_probe_cnt[k]++;
        if (m_probe_cnt[k] == 10) begin
          if (m_skip[k] < 65535) m_skip[k]++;
          m_int[k] = m_reload(k, in_sc[k]); m_probing[k] = 0;
        end
      end
    end else if (tick) begin
      m_int[k]--;
      if (m_int[k] == 0) begin
        m_probing[k] = 1; m_probe_lane[k] = int'(in_rnd[k] % 10); m_probe_cnt[k] = 0;
      end
    end
  endtask

  function automatic int expiring_lane(int k);
    if (m_tick[k] != p_tdiv(k) - 1) return -1;
    for (int i = 0; i < 10; i++) if (m_timer[k][i] == 1) return i;
    return -1;
  endfunction

  task automatic gen_inputs(input int k);
    int tgt, start;
    if (dis_left[k] == 0 && $urandom_range(0, 299) == 0) dis_left[k] = $urandom_range(1, 5);
    if (k == 0 && dis_left[k] == 0 && m_probing[k] != 0 && $urandom_range(0, 11) == 0) dis_left[k] = 2;
    in_en[k] = (dis_left[k] == 0);
    if (dis_left[k] > 0) dis_left[k]--;
    in_sc[k]  = cur_score;
    in_rnd[k] = $urandom();
    in_hv[k]  = ($urandom_range(0, (k == 0) ? 5 : 19) == 0);
    in_hl[k]  = 4'($urandom_range(0, 15));
    if (in_hv[k] && $urandom_range(0, 1) == 0) begin
      start = $urandom_range(0, 9);
      for (int j = 0; j < 10; j++)
        if (m_timer[k][(start + j) % 10] > 0) in_hl[k] = 4'((start + j) % 10);
    end
    tgt = expiring_lane(k);
    if (tgt >= 0 && $urandom_range(0, 1) == 0) begin in_hv[k] = 1'b1; in_hl[k] = 4'(tgt); end
    if (m_pending[k] >= 0 && $urandom_range(0, 2) == 0) begin
      in_hv[k] = 1'b1; in_hl[k] = 4'(m_pending[k]);
    end
  endtask

  task automatic compare_k(input int k);
    logic [31:0] o_mask, o_exp, o_lane, o_skip;
    logic o_sp, o_ok, o_miss;
    if (k == 0) begin
      o_mask = 32'(if0.active_mask); o_exp = 32'(if0.expire_mask); o_lane = 32'(if0.spawn_lane);
      o_skip = 32'(if0.skip_count); o_sp = if0.spawn_pulse; o_ok = if0.hit_ok; o_miss = if0.hit_miss;
    end else begin
      o_mask = 32'(if1.active_mask); o_exp = 32'(if1.expire_mask); o_lane = 32'(if1.spawn_lane);
      o_skip = 32'(if1.skip_count); o_sp = if1.spawn_pulse; o_ok = if1.hit_ok; o_miss = if1.hit_miss;
    end
    check($sformatf("u%0d.active_mask", k), o_mask, m_mask(k));
    check($sformatf("u%0d.expire_mask", k), o_exp, 32'(m_exp[k]));
    check($sformatf("u%0d.spawn_pulse", k), 32'(o_sp), 32'(m_spawn[k]));
    check($sformatf("u%0d.spawn_lane", k), o_lane, 32'(m_lane[k]));
    check($sformatf("u%0d.hit_ok", k), 32'(o_ok), 32'(m_ok[k]));
    check($sformatf("u%0d.hit_miss", k), 32'(o_miss), 32'(m_miss[k]));
    check($sformatf("u%0d.skip_count", k), o_skip, 32'(m_skip[k]));
  endtask

  task automatic run_cycle();
    if0.enable = in_en[0]; if0.score = in_sc[0]; if0.rand_in = in_rnd[0];
    if0.hit_valid = in_hv[0]; if0.hit_lane = in_hl[0];
    if1.enable = in_en[1]; if1.score = in_sc[1]; if1.rand_in = in_rnd[1];
    if1.hit_valid = in_hv[1]; if1.hit_lane = in_hl[1];
    for (int k = 0; k < 2; k++) model_step(k);
    if (m_spawn[0] != 0) exp_q.push_back(4'(m_lane[0]));
    @(posedge clock);
    @(negedge clock);
    compare_k(0);
    compare_k(1);
    if (if0.spawn_pulse) begin
      if (exp_q.size() > 0) check("u0.spawn_q_lane", 32'(if0.spawn_lane), 32'(exp_q.pop_front()));
      else check("u0.spawn_unexpected", 32'(exp_q.size()), 32'd1);
    end
  endtask

  task automatic set_fixed(input logic en, input logic [31:0] sc, input logic [31:0] rnd);
    for (int k = 0; k < 2; k++) begin
      in_en[k] = en; in_sc[k] = sc; in_rnd[k] = rnd; in_hv[k] = 1'b0; in_hl[k] = 4'd0;
    end
  endtask

  initial begin
    int first_cyc;
    logic [3:0] first_lane;
    set_fixed(1'b0, 32'd0, 32'd13);
    if0.enable = 1'b0; if0.score = '0; if0.rand_in = 32'd13; if0.hit_valid = 1'b0; if0.hit_lane = '0;
    if1.enable = 1'b0; if1.score = '0; if1.rand_in = 32'd13; if1.hit_valid = 1'b0; if1.hit_lane = '0;
    dis_left[0] = 0; dis_left[1] = 0; cur_score = '0;
    model_reset(0);
    model_reset(1);
    resetn = 1'b0;
    repeat (3) begin
      @(negedge clock);
      compare_k(0);
      compare_k(1);
    end
    resetn = 1'b1;

    first_cyc = -1;
    first_lane = '0;
    set_fixed(1'b1, 32'd0, 32'd13);
    for (int c = 1; c <= 40; c++) begin
      run_cycle();
      if (first_cyc < 0 && if0.spawn_pulse) begin first_cyc = c; first_lane = if0.spawn_lane; end
    end
    check("first_spawn_cycle", 32'(first_cyc), 32'd34);
    check("first_spawn_lane", 32'(first_lane), 32'd3);

    for (int c = 0; c < 6000; c++) begin
      if (c % 400 == 0) begin
        case ($urandom_range(0, 3))
          0: cur_score = 32'd0;
          1: cur_score = 32'd350;
          2: cur_score = 32'd10000;
          default: cur_score = 32'($urandom_range(0, 1000));
        endcase
      end
      gen_inputs(0);
      gen_inputs(1);
      run_cycle();
    end
    check("spawn_q_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
